traffic_light_controller: RTL and testbench

TRAFFIC_LIGHT_CONTROLLER -- requirements
Module: traffic_light_controller

---
 rtl/traffic_light_controller.sv | 91 +++++++++
 tb/tb_traffic_light_controller.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/traffic_light_controller.sv
// Purpose: six-phase Moore controller for a main road (two directions plus turn lane) and a side road.
// Latency: lamps decode from the state register only, so they change one clock edge after a phase ends.
// Backpressure: none; the phase sequence free-runs and only reset interrupts it.
module traffic_light_controller #(
  parameter int TMG = 7,  // main-road green, cycles
  parameter int TY  = 2,  // every yellow, cycles
  parameter int TTG = 5,  // main-turn green, cycles
  parameter int TSG = 3   // side-road green, cycles
) (
  input  logic       clk,
  input  logic       rst,        // asynchronous, active-low
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S
);

  // The counter only ever reaches (longest duration - 1), so it never wraps inside a phase.
  localparam int DMAX_A = (TMG > TY) ? TMG : TY;
  localparam int DMAX_B = (TTG > TSG) ? TTG : TSG;
  localparam int DMAX   = (DMAX_A > DMAX_B) ? DMAX_A : DMAX_B;
  localparam int CW     = (DMAX > 1) ? $clog2(DMAX) : 1;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef enum logic [2:0] {
    S1 = 3'd0,  // main green both directions
    S2 = 3'd1,  // direction 2 yellow
    S3 = 3'd2,  // direction 1 plus turn green
    S4 = 3'd3,  // direction 1 and turn yellow
    S5 = 3'd4,  // side green
    S6 = 3'd5   // side yellow
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [CW-1:0]   dur_m1;

  // State and phase counter; reset forces the start of S1 immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Advance to the next phase when the counter reaches its last cycle; illegal codes fall back to S1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    dur_m1    = '0;
    case (state)
      S1: begin dur_m1 = CW'(TMG - 1); if (cnt == dur_m1) state_nxt = S2; end
      S2: begin dur_m1 = CW'(TY - 1);  if (cnt == dur_m1) state_nxt = S3; end
      S3: begin dur_m1 = CW'(TTG - 1); if (cnt == dur_m1) state_nxt = S4; end
      S4: begin dur_m1 = CW'(TY - 1);  if (cnt == dur_m1) state_nxt = S5; end
      S5: begin dur_m1 = CW'(TSG - 1); if (cnt == dur_m1) state_nxt = S6; end
      S6: begin dur_m1 = CW'(TY - 1);  if (cnt == dur_m1) state_nxt = S1; end
      default: begin
        state_nxt = S1;
        cnt_nxt   = '0;
      end
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

  // Lamp decode from state only; illegal codes show all-red so the crossing stays safe.
  always_comb begin
    light_M1 = RED;
    light_M2 = RED;
    light_MT = RED;
    light_S  = RED;
    case (state)
      S1: begin light_M1 = GRN; light_M2 = GRN; end
      S2: begin light_M1 = GRN; light_M2 = YEL; end
      S3: begin light_M1 = GRN; light_MT = GRN; end
      S4: begin light_M1 = YEL; light_MT = YEL; end
      S5: light_S = GRN;
      S6: light_S = YEL;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Purpose: directed check of the traffic-light sequence for default and shortened timings.
// Latency: samples lamps 1 time unit after each falling clock edge, away from the active edge.
// Backpressure: not applicable; stimulus is reset only.
module tb_traffic_light_controller;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] d_m1, d_m2, d_mt, d_s;
  logic [2:0] p_m1, p_m2, p_mt, p_s;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  traffic_light_controller dut_dflt (
    .clk      (clk),
    .rst      (rst),
    .light_M1 (d_m1),
    .light_M2 (d_m2),
    .light_MT (d_mt),
    .light_S  (d_s)
  );

  traffic_light_controller #(.TMG(3), .TY(1), .TTG(2), .TSG(1)) dut_prm (
    .clk      (clk),
    .rst      (rst),
    .light_M1 (p_m1),
    .light_M2 (p_m2),
    .light_MT (p_mt),
    .light_S  (p_s)
  );

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  // Expected {M1,M2,MT,S} at position pos (0-based) within a repeating sequence.
  function automatic logic [11:0] exp_out(input int pos, input int tmg, input int ty,
                                          input int ttg, input int tsg);
    int p;
    p = pos % (tmg + ttg + tsg + 3 * ty);
    if (p < tmg) return {G, G, R, R};
    p -= tmg;
    if (p < ty) return {G, Y, R, R};
    p -= ty;
    if (p < ttg) return {G, R, G, R};
    p -= ttg;
    if (p < ty) return {Y, R, Y, R};
    p -= ty;
    if (p < tsg) return {R, R, R, G};
    return {R, R, R, Y};
  endfunction

  function automatic logic safe(input logic [2:0] m1, input logic [2:0] m2,
                                input logic [2:0] mt, input logic [2:0] s);
    logic ok;
    ok = 1'b1;
    if (s != R && (m1 != R || m2 != R || mt != R)) ok = 1'b0;
    if (mt != R && m2 != R) ok = 1'b0;
    return ok;
  endfunction

  // Compare both instances against the model for cycle k (1-based) since reset release.
  task automatic check_cycle(input int k, input string tag);
    check({tag, "_dflt"}, {d_m1, d_m2, d_mt, d_s}, exp_out(k - 1, 7, 2, 5, 3));
    check({tag, "_prm"},  {p_m1, p_m2, p_mt, p_s}, exp_out(k - 1, 3, 1, 2, 1));
  endtask

  logic [11:0] s1_vals;
  logic [2:0]  prev_s;
  int          last_entry;
  int          k;

  initial begin
    s1_vals = {G, G, R, R};

    // Reset held low from time 0: S1 lamps before any clock edge and throughout.
    rst = 1'b0;
    #1;
    check("rst_pre_edge_dflt", {d_m1, d_m2, d_mt, d_s}, s1_vals);
    check("rst_pre_edge_prm",  {p_m1, p_m2, p_mt, p_s}, s1_vals);
    repeat (2) begin
      @(negedge clk);
      #1;
      check("rst_hold_dflt", {d_m1, d_m2, d_mt, d_s}, s1_vals);
      check("rst_hold_prm",  {p_m1, p_m2, p_mt, p_s}, s1_vals);
    end

    // Release and run 2000 cycles; cycle 1 is the cycle right after release.
    @(negedge clk);
    rst = 1'b1;
    #1;
    last_entry = 0;
    prev_s     = d_s;
    for (k = 1; k <= 2000; k++) begin
      cyc = k;
      check_cycle(k, (k <= 22) ? "seq" : "run");
      check("onehot_dflt", {11'd0, $onehot(d_m1) && $onehot(d_m2) && $onehot(d_mt) && $onehot(d_s)}, 12'd1);
      check("onehot_prm",  {11'd0, $onehot(p_m1) && $onehot(p_m2) && $onehot(p_mt) && $onehot(p_s)}, 12'd1);
      check("safety_dflt", {11'd0, safe(d_m1, d_m2, d_mt, d_s)}, 12'd1);
      check("safety_prm",  {11'd0, safe(p_m1, p_m2, p_mt, p_s)}, 12'd1);
      // S1 entry is the side lamp going yellow -> red.
      if (prev_s == Y && d_s == R) begin
        if (last_entry > 0) check("period_dflt", 12'(k - last_entry), 12'd21);
        last_entry = k;
      end
      prev_s = d_s;
      @(negedge clk);
      #1;
    end

    // Advance to the first cycle of S5 (sequence position 16) in the default instance.
    while (((k - 1) % 21) != 16) begin
      cyc = k;
      check_cycle(k, "to_s5");
      k++;
      @(negedge clk);
      #1;
    end
    cyc = k;
    check("in_s5_dflt", {d_m1, d_m2, d_mt, d_s}, {R, R, R, G});

    // Asynchronous reset between edges: S1 lamps must appear before the next edge.
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_dflt", {d_m1, d_m2, d_mt, d_s}, s1_vals);
    check("async_rst_prm",  {p_m1, p_m2, p_mt, p_s}, s1_vals);
    @(negedge clk);
    #1;
    check("async_hold_dflt", {d_m1, d_m2, d_mt, d_s}, s1_vals);

    // Release again; S1 must last the full 7 cycles, then S2 follows.
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int j = 1; j <= 12; j++) begin
      cyc = j;
      check_cycle(j, "restart");
      @(negedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
